// File: rtl/sparse_mxv_pkg.sv
// Shared widths, FSM state encoding and helpers for the sparse_mxv row scheduler.
// Optional perf counters (SPARSE_MXV_CTRL_PERF_EN) use sat_inc.
package sparse_mxv_pkg;

    localparam int ROW_W_DEF    = 10;
    localparam int ADDR_W_DEF   = 16;
    localparam int CNT_W_DEF    = 14;
    localparam int PIPE_LAT_DEF = 6;
    localparam int PERF_W       = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_RD,
        S_LEN_WAIT,
        S_ARM,
        S_RUN,
        S_DRAIN,
        S_OUT,
        S_FIN
    } state_e;

    function automatic logic [PERF_W-1:0] sat_inc(
        input logic [PERF_W-1:0] v
    );
        return (&v) ? v : v + PERF_W'(1);
    endfunction

endpackage

// File: rtl/sparse_mxv_addr_gen.sv
// Weight/index read address counter: loads the layer base, then advances
// by one after every issued read, wrapping modulo 2**ADDR_W.
module sparse_mxv_addr_gen
    import sparse_mxv_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic              rd_en_d_i,
    output logic              w_rd_en_o,
    output logic [ADDR_W-1:0] w_addr_o
);

    logic              rd_en_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    always_comb begin
        addr_d = addr_q;
        if (load_i) begin
            addr_d = load_addr_i;
        end else if (rd_en_q) begin
            addr_d = addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_en_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            rd_en_q <= rd_en_d_i;
            addr_q  <= addr_d;
        end
    end

    assign w_rd_en_o = rd_en_q;
    assign w_addr_o  = addr_q;

endmodule

// File: rtl/sparse_mxv_ctrl.sv
// Row scheduler for one sparse_mxv bank: length fetch, arm/stream/drain, result handshake.
// Define SPARSE_MXV_CTRL_PERF_EN to add saturating busy/stall cycle counters.
module sparse_mxv_ctrl
    import sparse_mxv_pkg::*;
#(
    parameter int ROW_W    = ROW_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ROW_W-1:0]  cfg_rows,
    input  logic [ADDR_W-1:0] cfg_base,
    output logic              busy,
    output logic              done,
    output logic [ROW_W-1:0]  len_addr,
    input  logic [CNT_W-1:0]  len_rdata,
    output logic              w_rd_en,
    output logic [ADDR_W-1:0] w_addr,
    output logic              mxv_idle,
    output logic [CNT_W-1:0]  mxv_counter,
    input  logic [15:0]       mxv_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [15:0]       res_data,
    output logic [ROW_W-1:0]  res_row
`ifdef SPARSE_MXV_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_busy_cycles,
    output logic [31:0]       perf_stall_cycles
`endif
);

    state_e            state_q, state_d;
    logic [ROW_W-1:0]  rows_q, rows_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  ctr_q, ctr_d;
    logic [15:0]       res_q, res_d;
    logic              busy_q, done_q, idle_q, valid_q;
    logic              load;
    logic              rd_en_d;

    always_comb begin
        state_d = state_q;
        rows_d  = rows_q;
        row_d   = row_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        ctr_d   = ctr_q;
        res_d   = res_q;
        load    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    rows_d  = cfg_rows;
                    row_d   = '0;
                    load    = 1'b1;
                    state_d = (cfg_rows == '0) ? S_FIN : S_LEN_RD;
                end
            end
            S_LEN_RD: begin
                state_d = S_LEN_WAIT;
            end
            S_LEN_WAIT: begin
                len_d = len_rdata;
                if (len_rdata == '0) begin
                    res_d   = '0;
                    state_d = S_OUT;
                end else begin
                    ctr_d   = len_rdata - CNT_W'(1);
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                cnt_d   = len_q - CNT_W'(1);
                state_d = S_RUN;
            end
            // cnt_q holds the remaining cycles of the current phase
            S_RUN: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(PIPE_LAT - 1);
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) begin
                    res_d   = mxv_result;
                    state_d = S_OUT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_OUT: begin
                if (res_ready) begin
                    if (row_q == rows_q - ROW_W'(1)) begin
                        state_d = S_FIN;
                    end else begin
                        row_d   = row_q + ROW_W'(1);
                        state_d = S_LEN_RD;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Read word 0 in ARM, then one per RUN cycle except the last.
        rd_en_d = (state_d == S_ARM) ||
                  ((state_d == S_RUN) && (cnt_d != '0));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            rows_q  <= '0;
            row_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            ctr_q   <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idle_q  <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rows_q  <= rows_d;
            row_q   <= row_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            ctr_q   <= ctr_d;
            res_q   <= res_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_FIN);
            idle_q  <= (state_d != S_RUN) && (state_d != S_DRAIN);
            valid_q <= (state_d == S_OUT);
        end
    end

    sparse_mxv_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk_i       (clk),
        .rst_ni      (rst),
        .load_i      (load),
        .load_addr_i (cfg_base),
        .rd_en_d_i   (rd_en_d),
        .w_rd_en_o   (w_rd_en),
        .w_addr_o    (w_addr)
    );

    assign busy        = busy_q;
    assign done        = done_q;
    assign len_addr    = row_q;
    assign mxv_idle    = idle_q;
    assign mxv_counter = ctr_q;
    assign res_valid   = valid_q;
    assign res_data    = res_q;
    assign res_row     = row_q;

`ifdef SPARSE_MXV_CTRL_PERF_EN
    logic [31:0] pbusy_q, pstall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pbusy_q  <= '0;
            pstall_q <= '0;
        end else if ((state_q == S_IDLE) && start) begin
            pbusy_q  <= '0;
            pstall_q <= '0;
        end else begin
            if (busy_q) begin
                pbusy_q <= sat_inc(pbusy_q);
            end
            if ((state_q == S_OUT) && !res_ready) begin
                pstall_q <= sat_inc(pstall_q);
            end
        end
    end

    assign perf_busy_cycles  = pbusy_q;
    assign perf_stall_cycles = pstall_q;
`endif

endmodule

// File: tb/tb_sparse_mxv_ctrl.sv
// Self-checking bench for sparse_mxv_ctrl: directed layers plus random ones
// against a row-latency / address-stream reference model.
`timescale 1ns/1ps
module tb_sparse_mxv_ctrl;

    localparam int ROW_W  = 10;
    localparam int ADDR_W = 16;
    localparam int CNT_W  = 14;
    localparam int P      = 6;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ROW_W-1:0]  cfg_rows;
    logic [ADDR_W-1:0] cfg_base;
    logic              busy, done;
    logic [ROW_W-1:0]  len_addr;
    logic [CNT_W-1:0]  len_rdata;
    logic              w_rd_en;
    logic [ADDR_W-1:0] w_addr;
    logic              mxv_idle;
    logic [CNT_W-1:0]  mxv_counter;
    logic [15:0]       mxv_result;
    logic              res_valid, res_ready;
    logic [15:0]       res_data;
    logic [ROW_W-1:0]  res_row;
`ifdef SPARSE_MXV_CTRL_PERF_EN
    logic [31:0]       perf_busy_cycles, perf_stall_cycles;
`endif

    int checks   = 0;
    int failures = 0;
    int lens[0:1023];
    int stall[0:1023];

    sparse_mxv_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cfg_rows    (cfg_rows),
        .cfg_base    (cfg_base),
        .busy        (busy),
        .done        (done),
        .len_addr    (len_addr),
        .len_rdata   (len_rdata),
        .w_rd_en     (w_rd_en),
        .w_addr      (w_addr),
        .mxv_idle    (mxv_idle),
        .mxv_counter (mxv_counter),
        .mxv_result  (mxv_result),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_row     (res_row)
`ifdef SPARSE_MXV_CTRL_PERF_EN
        ,
        .perf_busy_cycles  (perf_busy_cycles),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Length table: one-cycle read latency.
    always @(posedge clk) len_rdata <= CNT_W'(lens[len_addr]);

    function automatic logic [15:0] bank_val(input logic [ROW_W-1:0] r);
        return 16'h5000 ^ (16'(r) * 16'd7);
    endfunction

    // Bank stand-in: a row-specific value only while the bank is running.
    always_comb mxv_result = mxv_idle ? 16'hDEAD : bank_val(len_addr);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".mxv_idle"}, mxv_idle, 1);
        chk({tag, ".mxv_counter"}, mxv_counter, 0);
        chk({tag, ".w_rd_en"}, w_rd_en, 0);
        chk({tag, ".w_addr"}, w_addr, 0);
        chk({tag, ".len_addr"}, len_addr, 0);
        chk({tag, ".res_valid"}, res_valid, 0);
        chk({tag, ".res_data"}, res_data, 0);
        chk({tag, ".res_row"}, res_row, 0);
`ifdef SPARSE_MXV_CTRL_PERF_EN
        chk({tag, ".perf_busy"}, perf_busy_cycles, 0);
        chk({tag, ".perf_stall"}, perf_stall_cycles, 0);
`endif
    endtask

    task automatic run_layer(input int rows, input logic [15:0] base,
                             input bit abort, input bit noise);
        int t, row, t_prev, reads, idle_lo, stall_left, t_exp;
        int tot_idle, exp_idle, tot_stall, t_done;
        bit fin, valid_seen, aborted;
        logic [15:0] nxt;
        exp_idle = 0;
        for (int i = 0; i < rows; i++)
            exp_idle += (lens[i] == 0) ? 0 : lens[i] + P;
        @(negedge clk);
        cfg_rows = ROW_W'(rows);
        cfg_base = base;
        start = 1'b1;
        res_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        t = 1; row = 0; t_prev = 0; reads = 0; idle_lo = 0;
        stall_left = 0; tot_idle = 0; tot_stall = 0; t_done = 0;
        fin = 0; valid_seen = 0; aborted = 0;
        nxt = base;
        while (!fin) begin
            if (t > 40000) begin
                chk("timeout", t, 0);
                break;
            end
            if (noise) begin
                cfg_rows = ROW_W'($urandom);
                cfg_base = ADDR_W'($urandom);
                start = ($urandom_range(0, 3) == 0);
            end
            chk("busy", busy, 1);
            if (w_rd_en) begin
                chk("w_addr", w_addr, nxt);
                nxt = nxt + 16'd1;
                reads++;
            end
            if (!mxv_idle) begin
                idle_lo++;
                tot_idle++;
                if (idle_lo == 1)
                    chk("mxv_counter", mxv_counter, lens[row] - 1);
            end
            if (abort && row == 1 && !mxv_idle) begin
                rst = 1'b0;
                #1;
                chk_reset_vals("async_rst");
                @(negedge clk);
                start = 1'b0;
                res_ready = 1'b0;
                chk_reset_vals("held_rst");
                rst = 1'b1;
                aborted = 1;
                fin = 1;
            end else if (done) begin
                chk("done_row", row, rows);
                chk("done_t", t, t_prev + 1);
                chk("idle_lo_total", tot_idle, exp_idle);
                start = 1'b0;
                res_ready = 1'b0;
                t_done = t;
                fin = 1;
            end else if (res_valid) begin
                if (row >= rows) begin
                    chk("extra_valid", res_valid, 0);
                    res_ready = 1'b1;
                end else begin
                    if (!valid_seen) begin
                        valid_seen = 1;
                        t_exp = t_prev + ((lens[row] == 0) ? 3 : 4 + lens[row] + P);
                        chk("res_lat", t, t_exp);
                        stall_left = stall[row];
                    end
                    chk("res_row", res_row, row);
                    chk("res_data", res_data,
                        (lens[row] == 0) ? 0 : bank_val(ROW_W'(row)));
                    if (stall_left > 0) begin
                        res_ready = 1'b0;
                        stall_left--;
                        tot_stall++;
                    end else begin
                        res_ready = 1'b1;
                        chk("row_reads", reads, lens[row]);
                        chk("row_idle_lo", idle_lo,
                            (lens[row] == 0) ? 0 : lens[row] + P);
                        row++;
                        t_prev = t;
                        reads = 0;
                        idle_lo = 0;
                        valid_seen = 0;
                    end
                end
            end else begin
                res_ready = 1'($urandom_range(0, 1));
            end
            if (!fin) begin
                @(negedge clk);
                t++;
            end
        end
        if (!aborted) begin
            @(negedge clk);
            chk("post_done", done, 0);
            chk("post_busy", busy, 0);
            chk("post_valid", res_valid, 0);
            chk("post_idle", mxv_idle, 1);
`ifdef SPARSE_MXV_CTRL_PERF_EN
            chk("perf_busy", perf_busy_cycles, t_done);
            chk("perf_stall", perf_stall_cycles, tot_stall);
`endif
        end
    endtask

    initial begin
        int rows;
        for (int i = 0; i < 1024; i++) begin
            lens[i] = 0;
            stall[i] = 0;
        end
        rst = 1'b0;
        start = 1'b0;
        cfg_rows = '0;
        cfg_base = '0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b1;

        lens[0] = 4;
        run_layer(1, 16'h0100, 0, 0);

        lens[0] = 2; lens[1] = 0; lens[2] = 5;
        run_layer(3, 16'h0000, 0, 0);

        lens[0] = 3; lens[1] = 1; stall[0] = 10;
        run_layer(2, 16'h0040, 0, 0);
        stall[0] = 0;

        run_layer(0, 16'h1234, 0, 0);

        lens[0] = 3; lens[1] = 4; lens[2] = 2;
        run_layer(3, 16'h0200, 1, 0);
        run_layer(3, 16'h0200, 0, 0);

        lens[0] = 4;
        run_layer(1, 16'hFFFE, 0, 0);

        lens[0] = 16383; lens[1] = 1;
        run_layer(2, 16'hC000, 0, 0);

        repeat (8) begin
            rows = $urandom_range(1, 6);
            for (int i = 0; i < rows; i++) begin
                lens[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 9);
                stall[i] = $urandom_range(0, 3);
            end
            run_layer(rows, 16'($urandom), 0, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
